// File: rtl/lsu_sram_ctrl.sv
// Load/store unit front end for a single-port-style SRAM: aligns stores into byte
// lanes, extracts and extends loads, and reports misalignment and read timeouts.
module lsu_sram_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   sram_rd_addr,
  output logic                    sram_rd_en,
  input  logic                    sram_rd_valid,
  input  logic [DATA_WIDTH-1:0]   sram_rd_data,
  output logic [ADDR_WIDTH-1:0]   sram_wr_addr,
  output logic                    sram_wr_en,
  output logic [DATA_WIDTH-1:0]   sram_wr_data,
  output logic [DATA_WIDTH/8-1:0] sram_mask
);

  localparam int NUM_OF_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W        = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STORE, LOAD, RESP} state_t;

  state_t                  state, next;
  logic                    rdy_q;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic [CNT_W-1:0]        cnt;

  logic                    accept;
  logic                    bad;
  logic                    timeout;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic [DATA_WIDTH-1:0]   ext;
  logic [ADDR_WIDTH-1:0]   addr_al;

  assign accept  = req_valid && req_ready;
  assign bad     = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  // rd_valid on the last allowed cycle takes priority over the timeout
  assign timeout = (state == LOAD) && !sram_rd_valid && (cnt == CNT_W'(RD_TIMEOUT - 1));
  assign addr_al = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    byte_v = sram_rd_data[{addr_q[1:0], 3'b000} +: 8];
    half_v = sram_rd_data[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ext = {{(DATA_WIDTH-8){~uns_q & byte_v[7]}}, byte_v};
      2'b01:   ext = {{(DATA_WIDTH-16){~uns_q & half_v[15]}}, half_v};
      default: ext = sram_rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= next;
      rdy_q <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)         next = RESP;
          else if (req_we) next = STORE;
          else             next = LOAD;
        end
      end
      STORE:   next = IDLE;
      LOAD:    if (sram_rd_valid || timeout) next = RESP;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= bad;
        cnt     <= '0;
      end else if (state == LOAD) begin
        cnt <= cnt + CNT_W'(1);
        if (sram_rd_valid) begin
          rdata_q <= ext;
          err_q   <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready    = (state == IDLE) && rdy_q;
    resp_valid   = (state == STORE) || (state == RESP);
    resp_err     = (state == RESP) && err_q;
    resp_rdata   = (state == RESP && !err_q && !we_q) ? rdata_q : '0;
    sram_rd_en   = (state == LOAD);
    sram_rd_addr = (state == LOAD) ? addr_al : '0;
    sram_wr_en   = (state == STORE);
    sram_wr_addr = '0;
    sram_wr_data = '0;
    sram_mask    = '0;
    if (state == STORE) begin
      sram_wr_addr = addr_al;
      case (size_q)
        2'b00: begin
          sram_wr_data = {NUM_OF_BYTES{wdata_q[7:0]}};
          sram_mask    = NUM_OF_BYTES'(1) << addr_q[1:0];
        end
        2'b01: begin
          sram_wr_data = {(NUM_OF_BYTES/2){wdata_q[15:0]}};
          sram_mask    = NUM_OF_BYTES'(3) << addr_q[1:0];
        end
        default: begin
          sram_wr_data = wdata_q;
          sram_mask    = '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Randomized self-checking bench for lsu_sram_ctrl against an arithmetic reference model.
module tb_lsu_sram_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] sram_rd_addr;
  logic        sram_rd_en;
  logic        sram_rd_valid = 1'b0;
  logic [31:0] sram_rd_data = '0;
  logic [31:0] sram_wr_addr;
  logic        sram_wr_en;
  logic [31:0] sram_wr_data;
  logic [3:0]  sram_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_sram_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_rd_addr(sram_rd_addr), .sram_rd_en(sram_rd_en),
    .sram_rd_valid(sram_rd_valid), .sram_rd_data(sram_rd_data),
    .sram_wr_addr(sram_wr_addr), .sram_wr_en(sram_wr_en),
    .sram_wr_data(sram_wr_data), .sram_mask(sram_mask)
  );

  // Reference model
  function automatic bit m_err(input int unsigned size, input logic [31:0] a);
    return (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_wdata(input int unsigned size, input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [3:0] m_mask(input int unsigned size, input logic [31:0] a);
    int unsigned m;
    if (size == 0)      m = 1 << (a % 4);
    else if (size == 1) m = 3 << (a % 4);
    else                m = 15;
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_load(input int unsigned size, input bit uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (size == 0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic present(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] a, input logic [31:0] w);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = a; req_wdata = w;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_unsigned = $urandom; req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 ||
        resp_rdata !== 32'h0 || resp_err !== 1'b0 || sram_mask !== 4'h0 || sram_rd_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rv=%b rd_en=%b wr_en=%b rdata=%h err=%b required all 0",
               req_ready, resp_valid, sram_rd_en, sram_wr_en, resp_rdata, resp_err);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ready_early: got %b required 0", req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] w);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL store_ready: got %b required 1", req_ready);
    end
    present(1'b1, size, 1'b0, a, w);
    sram_rd_valid = 1'b1;
    n_checks++;
    if (sram_wr_en !== 1'b1 || sram_wr_addr !== (a & ~32'h3) || sram_wr_data !== m_wdata(size, w) ||
        sram_mask !== m_mask(size, a) || resp_valid !== 1'b1 || resp_err !== 1'b0 ||
        resp_rdata !== 32'h0 || sram_rd_en !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL store a=%h sz=%0d: wr_en=%b addr=%h data=%h mask=%b rv=%b err=%b rd_en=%b required 1 %h %h %b 1 0 0",
               a, size, sram_wr_en, sram_wr_addr, sram_wr_data, sram_mask, resp_valid, resp_err,
               sram_rd_en, a & ~32'h3, m_wdata(size, w), m_mask(size, a));
    end
    @(negedge clk);
    sram_rd_valid = 1'b0;
    n_checks++;
    if (sram_wr_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || sram_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL store_end: wr_en=%b rv=%b ready=%b rd_en=%b required 0 0 1 0",
               sram_wr_en, resp_valid, req_ready, sram_rd_en);
    end
  endtask

  // lat = LOAD cycle on which rd_valid arrives; lat > TO means it never does
  task automatic test_load(input logic [1:0] size, input bit uns, input logic [31:0] a,
                           input logic [31:0] rd, input int unsigned lat);
    bit          exp_err;
    logic [31:0] exp_data;
    int unsigned k;
    exp_err  = (lat > TO);
    exp_data = exp_err ? 32'h0 : m_load(size, uns, a, rd);
    present(1'b0, size, uns, a, $urandom);
    for (k = 1; k <= TO; k++) begin
      n_checks++;
      if (sram_rd_en !== 1'b1 || sram_rd_addr !== (a & ~32'h3) || sram_wr_en !== 1'b0 ||
          resp_valid !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait a=%h cyc=%0d: rd_en=%b rd_addr=%h wr_en=%b rv=%b ready=%b required 1 %h 0 0 0",
                 a, k, sram_rd_en, sram_rd_addr, sram_wr_en, resp_valid, req_ready, a & ~32'h3);
      end
      sram_rd_valid = (k == lat);
      sram_rd_data  = (k == lat) ? rd : $urandom;
      @(posedge clk);
      @(negedge clk);
      if (k == lat) break;
    end
    sram_rd_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== exp_data ||
        sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL load_resp a=%h sz=%0d u=%0d lat=%0d: rv=%b err=%b rdata=%h rd_en=%b required 1 %b %h 0",
               a, size, uns, lat, resp_valid, resp_err, resp_rdata, sram_rd_en, exp_err, exp_data);
    end
    sram_rd_valid = 1'b1;
    @(negedge clk);
    sram_rd_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        req_ready !== 1'b1 || sram_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL load_end: rv=%b rdata=%h err=%b ready=%b rd_en=%b required 0 0 0 1 0",
               resp_valid, resp_rdata, resp_err, req_ready, sram_rd_en);
    end
  endtask

  task automatic test_error(input bit we, input logic [1:0] size, input logic [31:0] a);
    present(we, size, $urandom, a, $urandom);
    n_checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 ||
        sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL error_resp a=%h sz=%0d we=%0d: rv=%b err=%b rdata=%h rd_en=%b wr_en=%b required 1 1 0 0 0",
               a, size, we, resp_valid, resp_err, resp_rdata, sram_rd_en, sram_wr_en);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1 || sram_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL error_end: rv=%b err=%b ready=%b rd_en=%b required 0 0 1 0",
               resp_valid, resp_err, req_ready, sram_rd_en);
    end
  endtask

  task automatic test_reset_abort(input bit we);
    present(we, 2'b10, 1'b0, 32'h0000_4000, 32'h1234_5678);
    if (!we) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort we=%0d: rd_en=%b wr_en=%b rv=%b ready=%b required 0 0 0 0",
               we, sram_rd_en, sram_wr_en, resp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || sram_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_recover: ready=%b rv=%b rd_en=%b required 1 0 0",
               req_ready, resp_valid, sram_rd_en);
    end
  endtask

  task automatic test_random(input int unsigned n);
    bit          we, uns;
    logic [1:0]  size;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      we   = $urandom;
      uns  = $urandom;
      size = 2'($urandom);
      a    = $urandom;
      if (m_err(size, a))  test_error(we, size, a);
      else if (we)         test_store(size, a, $urandom);
      else                 test_load(size, uns, a, $urandom, $urandom_range(1, TO + 2));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_store(2'b00, 32'h0000_1002, 32'h0000_00AB);
    test_load(2'b01, 1'b0, 32'h0000_2002, 32'h8001_1234, 3);
    test_error(1'b0, 2'b10, 32'h0000_3001);
    test_error(1'b1, 2'b11, 32'h0000_3000);
    test_error(1'b0, 2'b01, 32'h0000_3003);
    test_load(2'b10, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, TO + 1);
    test_load(2'b10, 1'b0, 32'h0000_3000, 32'hDEAD_BEEF, TO);
    test_store(2'b10, 32'h0000_1000, 32'hCAFE_F00D);
    test_load(2'b00, 1'b1, 32'h0000_1003, 32'h8000_0000, 1);
    test_store(2'b01, 32'h0000_1002, 32'h0000_BEEF);
    test_load(2'b00, 1'b0, 32'h0000_1001, 32'h0000_9000, 2);
    test_reset_abort(1'b0);
    test_reset_abort(1'b1);
    test_random(60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
